// File: rtl/fifo_controller_pkg.sv
// Shared types and constants for the 8-entry FIFO control stage.
package fifo_controller_pkg;

    localparam int unsigned FIFO_DATA_W = 32;
    localparam int unsigned FIFO_ADDR_W = 3;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_NO_OP    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WR_ERROR = 3'd3,
        ST_READ     = 3'd4,
        ST_RD_ERROR = 3'd5
    } state_e;

    typedef struct packed {
        logic wr_ack;
        logic wr_err;
        logic rd_ack;
        logic rd_err;
    } flags_t;

    // Simultaneous requests are deliberately ignored (NO_OP), not treated as an error.
    function automatic state_e next_state(input logic wr, input logic rd,
                                          input logic full, input logic empty);
        state_e ns;
        ns = ST_NO_OP;
        if (wr && !rd)      ns = full  ? ST_WR_ERROR : ST_WRITE;
        else if (rd && !wr) ns = empty ? ST_RD_ERROR : ST_READ;
        return ns;
    endfunction

endpackage

// File: rtl/fifo_controller_cal.sv
// Next head/tail/count and register-file write enable from the current request and occupancy.
module fifo_controller_cal
    import fifo_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_W
) (
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  full_i,
    input  logic                  empty_i,
    input  logic [ADDR_WIDTH-1:0] head_i,
    input  logic [ADDR_WIDTH-1:0] tail_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    output logic                  we_o,
    output logic                  rd_acc_o,
    output logic [ADDR_WIDTH-1:0] head_d_o,
    output logic [ADDR_WIDTH-1:0] tail_d_o,
    output logic [ADDR_WIDTH:0]   count_d_o
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    always_comb begin
        we_o      = wr_en_i & ~rd_en_i & ~full_i;
        rd_acc_o  = rd_en_i & ~wr_en_i & ~empty_i;
        head_d_o  = head_i;
        tail_d_o  = tail_i;
        count_d_o = count_i;
        // Pointers wrap naturally at 2**ADDR_WIDTH; count is bounded by full/empty gating.
        if (we_o) begin
            tail_d_o  = tail_i + ADDR_WIDTH'(1);
            count_d_o = count_i + CW'(1);
        end else if (rd_acc_o) begin
            head_d_o  = head_i + ADDR_WIDTH'(1);
            count_d_o = count_i - CW'(1);
        end
    end

endmodule

// File: rtl/fifo_controller.sv
// FIFO control and output stage: state register, pointers, occupancy count and registered read data.
module fifo_controller
    import fifo_controller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_W,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [ADDR_WIDTH-1:0] rAddr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);

    state_e                state_q, state_d;
    flags_t                flags;
    logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  we_c, rd_acc_c;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

    fifo_controller_cal #(.ADDR_WIDTH(ADDR_WIDTH)) u_cal (
        .wr_en_i   (wr_en),
        .rd_en_i   (rd_en),
        .full_i    (full),
        .empty_i   (empty),
        .head_i    (head_q),
        .tail_i    (tail_q),
        .count_i   (count_q),
        .we_o      (we_c),
        .rd_acc_o  (rd_acc_c),
        .head_d_o  (head_d),
        .tail_d_o  (tail_d),
        .count_d_o (count_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = next_state(wr_en, rd_en, full, empty);
    end

    // Handshake flags are a pure decode of the registered state.
    always_comb begin
        flags = '0;
        case (state_q)
            ST_WRITE:    flags.wr_ack = 1'b1;
            ST_WR_ERROR: flags.wr_err = 1'b1;
            ST_READ:     flags.rd_ack = 1'b1;
            ST_RD_ERROR: flags.rd_err = 1'b1;
            default:     flags = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (rd_acc_c) dout_q <= rd_data;
        end
    end

    // Reset must kill a pending register-file write without waiting for an edge.
    assign we         = we_c & ~reset;
    assign wAddr      = tail_q;
    assign rAddr      = head_q;
    assign dout       = dout_q;
    assign data_count = count_q;
    assign wr_ack     = flags.wr_ack;
    assign wr_err     = flags.wr_err;
    assign rd_ack     = flags.rd_ack;
    assign rd_err     = flags.rd_err;

endmodule

// File: tb/tb_fifo_controller.sv
// Directed table-driven bench for fifo_controller with a behavioural 8x32 register file.
module tb_fifo_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, rd_en;
    logic [31:0] rd_data;
    logic        we;
    logic [2:0]  wAddr, rAddr;
    logic [31:0] dout;
    logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
    logic [3:0]  data_count;

    logic [31:0] mem [8];
    logic [31:0] wdata;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_WA   = 4'b1000;
    localparam logic [3:0] F_WE   = 4'b0100;
    localparam logic [3:0] F_RA   = 4'b0010;
    localparam logic [3:0] F_RE   = 4'b0001;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] data;
        logic        exp_we;
        logic [2:0]  exp_wa;
        logic [2:0]  exp_ra;
        logic [3:0]  exp_flags;
        logic [3:0]  exp_cnt;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    fifo_controller dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .we         (we),
        .wAddr      (wAddr),
        .rAddr      (rAddr),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .data_count (data_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (we) mem[wAddr] <= wdata;
    assign rd_data = mem[rAddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_post(input string tag, input logic [3:0] f, input logic [3:0] cnt,
                            input logic [31:0] d);
        chk({tag, " flags"}, 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'(f));
        chk({tag, " count"}, 32'(data_count), 32'(cnt));
        chk({tag, " dout"},  dout, d);
        chk({tag, " empty"}, 32'(empty), 32'(cnt == 4'd0));
        chk({tag, " full"},  32'(full),  32'(cnt == 4'd8));
    endtask

    function automatic vec_t mk(logic wr, logic rd, logic [31:0] data, logic ewe,
                                logic [2:0] ewa, logic [2:0] era, logic [3:0] ef,
                                logic [3:0] ec, logic [31:0] ed);
        vec_t v;
        v.wr = wr; v.rd = rd; v.data = data; v.exp_we = ewe; v.exp_wa = ewa;
        v.exp_ra = era; v.exp_flags = ef; v.exp_cnt = ec; v.exp_dout = ed;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;

        // Three writes, two reads
        vecs.push_back(mk(1, 0, 32'h11, 1, 3'd0, 3'd0, F_WA, 4'd1, 32'h0));
        vecs.push_back(mk(1, 0, 32'h22, 1, 3'd1, 3'd0, F_WA, 4'd2, 32'h0));
        vecs.push_back(mk(1, 0, 32'h33, 1, 3'd2, 3'd0, F_WA, 4'd3, 32'h0));
        vecs.push_back(mk(0, 1, 32'h0,  0, 3'd3, 3'd0, F_RA, 4'd2, 32'h11));
        vecs.push_back(mk(0, 1, 32'h0,  0, 3'd3, 3'd1, F_RA, 4'd1, 32'h22));
        // Fill to 8 (tail wraps 7->0), then one refused write
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1, 0, 32'h44 + 32'h11 * 32'(i), 1, 3'((3 + i) % 8), 3'd2,
                              F_WA, 4'(2 + i), 32'h22));
        vecs.push_back(mk(1, 0, 32'hBB, 0, 3'd2, 3'd2, F_WE, 4'd8, 32'h22));
        // Drain 8 in order (head wraps 7->0)
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 32'h0, 0, 3'd2, 3'((2 + i) % 8), F_RA, 4'(7 - i),
                              32'h33 + 32'h11 * 32'(i)));
        vecs.push_back(mk(0, 1, 32'h0, 0, 3'd2, 3'd2, F_RE,   4'd0, 32'hAA));
        vecs.push_back(mk(0, 0, 32'h0, 0, 3'd2, 3'd2, F_NONE, 4'd0, 32'hAA));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 32'(i + 1), 1, 3'(2 + i), 3'd2, F_WA, 4'(i + 1), 32'hAA));
        // Simultaneous requests are ignored
        vecs.push_back(mk(1, 1, 32'hEE, 0, 3'd6, 3'd2, F_NONE, 4'd4, 32'hAA));
        vecs.push_back(mk(0, 0, 32'h0,  0, 3'd6, 3'd2, F_NONE, 4'd4, 32'hAA));
        vecs.push_back(mk(1, 0, 32'h05, 1, 3'd6, 3'd2, F_WA,   4'd5, 32'hAA));

        #3;
        chk_post("reset", F_NONE, 4'd0, 32'h0);
        chk("reset we", 32'(we), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_post("idle", F_NONE, 4'd0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            wr_en = vecs[i].wr; rd_en = vecs[i].rd; wdata = vecs[i].data;
            #1;
            chk({tag, " we"},    32'(we),    32'(vecs[i].exp_we));
            chk({tag, " wAddr"}, 32'(wAddr), 32'(vecs[i].exp_wa));
            chk({tag, " rAddr"}, 32'(rAddr), 32'(vecs[i].exp_ra));
            @(posedge clk); #1;
            chk_post(tag, vecs[i].exp_flags, vecs[i].exp_cnt, vecs[i].exp_dout);
        end

        // Reset asserted mid-write with count=5
        wr_en = 1'b1; rd_en = 1'b0; wdata = 32'h66;
        #1;
        chk("pre-rst we",    32'(we),    32'd1);
        chk("pre-rst wAddr", 32'(wAddr), 32'd7);
        #1;
        reset = 1'b1;
        #1;
        chk("mid-rst we",    32'(we),    32'd0);
        chk("mid-rst wAddr", 32'(wAddr), 32'd0);
        chk("mid-rst rAddr", 32'(rAddr), 32'd0);
        chk_post("mid-rst", F_NONE, 4'd0, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-rst we",    32'(we),    32'd1);
        chk("post-rst wAddr", 32'(wAddr), 32'd0);
        @(posedge clk); #1;
        chk_post("post-rst", F_WA, 4'd1, 32'h0);
        wr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
